deal_sequencer: RTL



---
 rtl/baccarat_pkg.sv | 21 ++
 rtl/banker_rule.sv | 26 ++
 rtl/deal_sequencer.sv | 75 +++++++
 3 files changed

// File: rtl/baccarat_pkg.sv
// Shared definitions for the Baccarat (Punto Banco) round controller and its helpers.
package baccarat_pkg;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_P1   = 4'd1,
    S_D1   = 4'd2,
    S_P2   = 4'd3,
    S_D2   = 4'd4,
    S_EVAL = 4'd5,
    S_P3   = 4'd6,
    S_BANK = 4'd7,
    S_D3   = 4'd8,
    S_DONE = 4'd9
  } state_t;

  localparam logic [3:0] NATURAL_MIN     = 4'd8;
  localparam logic [3:0] PLAYER_DRAW_MAX = 4'd5;
  localparam logic [3:0] FACE_MIN        = 4'd10;

endpackage

// File: rtl/banker_rule.sv
// Banker third-card tableau: decides whether the banker draws, given the
// banker score and the player's third card (faces and tens count as zero).
module banker_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  logic [3:0] tv;

  always_comb begin
    tv   = (pcard3 >= FACE_MIN) ? 4'd0 : pcard3;
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (tv != 4'd8);
      4'd4:             draw = (tv >= 4'd2) && (tv <= 4'd7);
      4'd5:             draw = (tv >= 4'd4) && (tv <= 4'd7);
      4'd6:             draw = (tv >= 4'd6) && (tv <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/deal_sequencer.sv
// Round controller: sequences the six card-load strobes, applies the natural
// and third-card rules from datapath feedback, and lights the winner.
module deal_sequencer
  import baccarat_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       round_done
);

  state_t state, state_next;
  logic   banker_draw;
  logic   natural;

  banker_rule u_banker_rule (
    .dscore (dscore),
    .pcard3 (pcard3),
    .draw   (banker_draw)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  assign natural = (pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN);

  // Unlisted encodings fall back to IDLE so an upset can never wedge the round.
  always_comb begin
    state_next = S_IDLE;
    case (state)
      S_IDLE: state_next = start ? S_P1 : S_IDLE;
      S_P1:   state_next = S_D1;
      S_D1:   state_next = S_P2;
      S_P2:   state_next = S_D2;
      S_D2:   state_next = S_EVAL;
      S_EVAL: begin
        if (natural)                        state_next = S_DONE;
        else if (pscore <= PLAYER_DRAW_MAX) state_next = S_P3;
        else if (dscore <= PLAYER_DRAW_MAX) state_next = S_D3;
        else                                state_next = S_DONE;
      end
      S_P3:   state_next = S_BANK;
      S_BANK: state_next = banker_draw ? S_D3 : S_DONE;
      S_D3:   state_next = S_DONE;
      S_DONE: state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    load_pcard1      = (state == S_P1);
    load_dcard1      = (state == S_D1);
    load_pcard2      = (state == S_P2);
    load_dcard2      = (state == S_D2);
    load_pcard3      = (state == S_P3);
    load_dcard3      = (state == S_D3);
    round_done       = (state == S_DONE);
    player_win_light = round_done && (pscore >= dscore);
    dealer_win_light = round_done && (dscore >= pscore);
  end

endmodule
